mcoc_boot_arb: RTL and testbench

- Two-port arbiter and read sequencer in front of the 32-bit boot ROM fetch port (fcmdl/fadr in, fdat out, fdat registered one cycle after fadr).
- Shares the port between the CPU instruction fetch (port I) and a debug/loader data-read port (port D).
- Tracks ownership of in-flight reads and routes each response to its requester.
- Sustains one read per cycle and adds an out-of-range check.

---
 rtl/mcoc_boot_arb.sv | 190 +++++++++++++++++++
 tb/tb_mcoc_boot_arb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcoc_boot_arb.sv
// -----------------------------------------------------------------------------
// mcoc_boot_arb
//
// Purpose:
//   Two-port arbiter and read sequencer for the 32-bit boot ROM fetch port.
//   The CPU instruction fetch (port I) and the debug/loader data read
//   (port D) share the port. The block issues one read per cycle, tracks
//   which port owns each read in flight, and routes each response back to
//   that port. It also checks every address against the ROM size.
//
//   Pipeline (t = grant cycle):
//     t   : combinational grant, winner's address/width selected
//     t+1 : fadr/fcmdl presented to the ROM (stage 1 holds owner + range)
//     t+2 : ROM data on fdat, stage 2 steers it to the owner
//   The latency is a fixed 2 cycles. Responses return in issue order, and
//   there is no response backpressure.
//
// Parameters:
//   ROM_AW : byte-address width of the ROM. An address is out of range when
//            any of adr[15:ROM_AW] is set.
//   RR_EN  : 1 = round-robin between I and D. 0 = fixed priority, I wins.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_req/i_adr/i_cmdl : instruction read request, byte address, width
//   i_gnt            : I request accepted this cycle
//   i_vld/i_dat      : I response valid / data (0 when out of range)
//   d_req/d_adr/d_cmdl : data read request, byte address, width
//   d_gnt            : D request accepted this cycle
//   d_vld/d_dat      : D response valid / data (0 when out of range)
//   d_err            : qualifies d_vld, the address was out of range
//   fadr/fcmdl       : registered ROM address / width select
//   fdat             : ROM read data, registered inside the ROM
// -----------------------------------------------------------------------------
module mcoc_boot_arb #(
  parameter int ROM_AW = 8,
  parameter bit RR_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_adr,
  input  logic        i_cmdl,
  output logic        i_gnt,
  output logic        i_vld,
  output logic [31:0] i_dat,
  input  logic        d_req,
  input  logic [15:0] d_adr,
  input  logic        d_cmdl,
  output logic        d_gnt,
  output logic        d_vld,
  output logic [31:0] d_dat,
  output logic        d_err,
  output logic [15:0] fadr,
  output logic        fcmdl,
  input  logic [31:0] fdat
);

  // Owner tags carried down the pipeline.
  localparam logic TAG_I = 1'b0;
  localparam logic TAG_D = 1'b1;

  // True when the address reaches past the ROM (any bit at or above ROM_AW).
  function automatic logic addr_oor(input logic [15:0] adr);
    logic [15:0] hi;
    hi = adr >> ROM_AW;
    return (hi != 16'h0000);
  endfunction

  // Arbitration state and pipeline stages.
  logic        rr_last_r;   // last granted port, reset to D so I wins first
  logic        s1_vld_r;
  logic        s1_tag_r;
  logic        s1_oor_r;
  logic        s2_vld_r;
  logic        s2_tag_r;
  logic        s2_oor_r;

  // Winner selection results.
  logic        gnt_any_s;
  logic        win_tag_s;
  logic [15:0] win_adr_s;
  logic        win_cmdl_s;
  logic [31:0] resp_dat_s;

  // Grant decision: a single requester always wins. On contention, pick by
  // round-robin (the port not granted last) or by fixed I priority.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (i_req && d_req) begin
      if ((RR_EN == 1'b1) && (rr_last_r == TAG_I)) begin
        d_gnt = 1'b1;
      end else begin
        i_gnt = 1'b1;
      end
    end else if (i_req) begin
      i_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end else begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
    end
  end

  // Steer the winner's address and width towards the issue register.
  always_comb begin
    gnt_any_s  = i_gnt | d_gnt;
    win_tag_s  = TAG_I;
    win_adr_s  = i_adr;
    win_cmdl_s = i_cmdl;
    if (d_gnt) begin
      win_tag_s  = TAG_D;
      win_adr_s  = d_adr;
      win_cmdl_s = d_cmdl;
    end else begin
      win_tag_s  = TAG_I;
      win_adr_s  = i_adr;
      win_cmdl_s = i_cmdl;
    end
  end

  // Issue stage: launch the granted read to the ROM and record its owner.
  // With no grant the ROM address holds and stage 1 empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fadr      <= 16'h0000;
      fcmdl     <= 1'b0;
      s1_vld_r  <= 1'b0;
      s1_tag_r  <= TAG_I;
      s1_oor_r  <= 1'b0;
      rr_last_r <= TAG_D;
    end else begin
      if (gnt_any_s) begin
        fadr      <= win_adr_s;
        fcmdl     <= win_cmdl_s;
        s1_vld_r  <= 1'b1;
        s1_tag_r  <= win_tag_s;
        s1_oor_r  <= addr_oor(win_adr_s);
        rr_last_r <= win_tag_s;
      end else begin
        s1_vld_r  <= 1'b0;
      end
    end
  end

  // Data stage: follows the ROM's own output register by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_r <= 1'b0;
      s2_tag_r <= TAG_I;
      s2_oor_r <= 1'b0;
    end else begin
      s2_vld_r <= s1_vld_r;
      s2_tag_r <= s1_tag_r;
      s2_oor_r <= s1_oor_r;
    end
  end

  // Response steering: only the owner sees data. Out-of-range reads return
  // zero. Only port D gets an error flag, because the CPU traps I-side range
  // faults elsewhere.
  always_comb begin
    i_vld = 1'b0;
    d_vld = 1'b0;
    i_dat = 32'h0000_0000;
    d_dat = 32'h0000_0000;
    d_err = 1'b0;
    if (s2_oor_r) begin
      resp_dat_s = 32'h0000_0000;
    end else begin
      resp_dat_s = fdat;
    end
    if (s2_vld_r) begin
      if (s2_tag_r == TAG_D) begin
        d_vld = 1'b1;
        d_dat = resp_dat_s;
        d_err = s2_oor_r;
      end else begin
        i_vld = 1'b1;
        i_dat = resp_dat_s;
      end
    end else begin
      i_vld = 1'b0;
      d_vld = 1'b0;
    end
  end

endmodule

// File: tb/tb_mcoc_boot_arb.sv
// -----------------------------------------------------------------------------
// tb_mcoc_boot_arb
//
// Self-checking bench for mcoc_boot_arb. The main instance uses RR_EN=1. A
// second instance with RR_EN=0 shares the request inputs. Each instance has
// its own ROM model that registers fdat one cycle after fadr. A scoreboard
// model pushes the expected response for every grant and pops it two cycles
// later. The bench also runs directed checks for the named scenarios.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mcoc_boot_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0;
  logic [15:0] i_adr = 16'h0, d_adr = 16'h0;
  logic        i_cmdl = 1'b0, d_cmdl = 1'b0;

  logic        i_gnt, i_vld, d_gnt, d_vld, d_err, fcmdl;
  logic [31:0] i_dat, d_dat;
  logic [15:0] fadr;
  logic [31:0] fdat = 32'h0;

  logic        fp_i_gnt, fp_i_vld, fp_d_gnt, fp_d_vld, fp_d_err, fp_fcmdl;
  logic [31:0] fp_i_dat, fp_d_dat;
  logic [15:0] fp_fadr;
  logic [31:0] fp_fdat = 32'h0;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mcoc_boot_arb #(.ROM_AW(8), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_adr(i_adr), .i_cmdl(i_cmdl), .i_gnt(i_gnt),
    .i_vld(i_vld), .i_dat(i_dat),
    .d_req(d_req), .d_adr(d_adr), .d_cmdl(d_cmdl), .d_gnt(d_gnt),
    .d_vld(d_vld), .d_dat(d_dat), .d_err(d_err),
    .fadr(fadr), .fcmdl(fcmdl), .fdat(fdat)
  );

  mcoc_boot_arb #(.ROM_AW(8), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_adr(i_adr), .i_cmdl(i_cmdl), .i_gnt(fp_i_gnt),
    .i_vld(fp_i_vld), .i_dat(fp_i_dat),
    .d_req(d_req), .d_adr(d_adr), .d_cmdl(d_cmdl), .d_gnt(fp_d_gnt),
    .d_vld(fp_d_vld), .d_dat(fp_d_dat), .d_err(fp_d_err),
    .fadr(fp_fadr), .fcmdl(fp_fcmdl), .fdat(fp_fdat)
  );

  // ROM contents: 64 words. The word at byte 0x0010 is 0x12345678.
  logic [31:0] rom_mem [0:63];
  initial begin
    for (int k = 0; k < 64; k++) rom_mem[k] = 32'hA5000000 | (k * 32'h00010203);
    rom_mem[0] = 32'hDEADBEEF;
    rom_mem[4] = 32'h12345678;
  end

  // ROM read: full word, or the halfword picked by adr[1] (adr[1]=1 -> low half).
  function automatic logic [31:0] rom_read(input logic [15:0] adr, input logic cmdl);
    logic [31:0] w;
    w = rom_mem[adr[7:2]];
    if (cmdl) return w;
    else if (adr[1]) return {16'h0000, w[15:0]};
    else return {16'h0000, w[31:16]};
  endfunction

  always @(posedge clk) begin
    fdat    <= rom_read(fadr, fcmdl);
    fp_fdat <= rom_read(fp_fadr, fp_fcmdl);
    cyc     <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard and reference model for the main (round-robin) instance.
  typedef struct {
    int          due;
    logic        tag;
    logic [31:0] dat;
    logic        err;
  } resp_t;
  resp_t       exp_q[$];
  logic        rr_last_m = 1'b1;
  logic [15:0] exp_fadr_m = 16'h0;
  logic        exp_fcmdl_m = 1'b0;
  resp_t       mon_e;
  logic        mon_ig, mon_dg, mon_oor;
  logic [15:0] mon_adr;
  logic        mon_cmdl;

  // Reset drops everything in flight.
  always @(negedge rst_n) begin
    exp_q.delete();
    rr_last_m   = 1'b1;
    exp_fadr_m  = 16'h0;
    exp_fcmdl_m = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        mon_e = exp_q.pop_front();
        if (mon_e.tag == 1'b0) begin
          check_eq("i_vld", {31'h0, i_vld}, 32'h1);
          check_eq("i_dat", i_dat, mon_e.dat);
          check_eq("d_vld_idle", {31'h0, d_vld}, 32'h0);
          check_eq("d_dat_nonowner", d_dat, 32'h0);
          check_eq("d_err_idle", {31'h0, d_err}, 32'h0);
        end else begin
          check_eq("d_vld", {31'h0, d_vld}, 32'h1);
          check_eq("d_dat", d_dat, mon_e.dat);
          check_eq("d_err", {31'h0, d_err}, {31'h0, mon_e.err});
          check_eq("i_vld_idle", {31'h0, i_vld}, 32'h0);
          check_eq("i_dat_nonowner", i_dat, 32'h0);
        end
      end else begin
        check_eq("i_vld_none", {31'h0, i_vld}, 32'h0);
        check_eq("d_vld_none", {31'h0, d_vld}, 32'h0);
        check_eq("d_err_none", {31'h0, d_err}, 32'h0);
      end
      check_eq("fadr", {16'h0, fadr}, {16'h0, exp_fadr_m});
      check_eq("fcmdl", {31'h0, fcmdl}, {31'h0, exp_fcmdl_m});
      mon_ig = 1'b0;
      mon_dg = 1'b0;
      if (i_req && d_req) begin
        if (rr_last_m == 1'b1) mon_ig = 1'b1; else mon_dg = 1'b1;
      end else begin
        mon_ig = i_req;
        mon_dg = d_req;
      end
      check_eq("i_gnt", {31'h0, i_gnt}, {31'h0, mon_ig});
      check_eq("d_gnt", {31'h0, d_gnt}, {31'h0, mon_dg});
      if (mon_ig || mon_dg) begin
        mon_adr   = mon_dg ? d_adr : i_adr;
        mon_cmdl  = mon_dg ? d_cmdl : i_cmdl;
        mon_oor   = (mon_adr[15:8] != 8'h00);
        mon_e.due = cyc + 2;
        mon_e.tag = mon_dg;
        mon_e.dat = mon_oor ? 32'h0 : rom_read(mon_adr, mon_cmdl);
        mon_e.err = mon_oor & mon_dg;
        exp_q.push_back(mon_e);
        rr_last_m   = mon_dg;
        exp_fadr_m  = mon_adr;
        exp_fcmdl_m = mon_cmdl;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    step(); step();
    rst_n = 1'b1;
    check_eq("rst_fadr", {16'h0, fadr}, 32'h0);
    check_eq("rst_vld", {30'h0, i_vld, d_vld}, 32'h0);
    step();

    // Test 1: I word read at 0x0010.
    i_req = 1'b1; i_adr = 16'h0010; i_cmdl = 1'b1;
    step(); idle();
    check_eq("t1_fadr", {16'h0, fadr}, 32'h0010);
    step();
    check_eq("t1_i_dat", i_dat, 32'h12345678);
    check_eq("t1_d_vld", {31'h0, d_vld}, 32'h0);
    step();

    // Test 2: D halfword reads, low half at 0x0012, high half at 0x0010.
    d_req = 1'b1; d_adr = 16'h0012; d_cmdl = 1'b0;
    step(); idle(); step();
    check_eq("t2_lo", d_dat, 32'h00005678);
    check_eq("t2_err", {31'h0, d_err}, 32'h0);
    d_req = 1'b1; d_adr = 16'h0010;
    step(); idle(); step();
    check_eq("t2_hi", d_dat, 32'h00001234);
    step();

    // Test 5: out-of-range reads on both ports, then 0xFFFF on D.
    d_req = 1'b1; d_adr = 16'h0100; d_cmdl = 1'b1;
    step(); idle();
    i_req = 1'b1; i_adr = 16'h0100; i_cmdl = 1'b1;
    step(); idle();
    d_req = 1'b1; d_adr = 16'hFFFF;
    check_eq("t5_d_oor", {d_vld, d_err, 30'h0} | {2'b0, d_dat[29:0]}, 32'hC0000000);
    step(); idle();
    check_eq("t5_i_oor", i_dat, 32'h0);
    check_eq("t5_i_vld", {31'h0, i_vld}, 32'h1);
    step();
    check_eq("t5_ffff_err", {31'h0, d_err}, 32'h1);
    step();

    // Tests 3/4: both ports request continuously. The round-robin instance
    // alternates starting with I, and the fixed-priority one always grants I.
    i_req = 1'b1; i_adr = 16'h0020; i_cmdl = 1'b1;
    d_req = 1'b1; d_adr = 16'h0030; d_cmdl = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #2;
      check_eq("rr_i_gnt", {31'h0, i_gnt}, (k % 2 == 0) ? 32'h1 : 32'h0);
      check_eq("fp_i_gnt", {31'h0, fp_i_gnt}, 32'h1);
      check_eq("fp_d_gnt", {31'h0, fp_d_gnt}, 32'h0);
      step();
    end
    i_req = 1'b0;
    #2;
    check_eq("fp_d_gnt_drop", {31'h0, fp_d_gnt}, 32'h1);
    step(); d_req = 1'b0; step();
    check_eq("fp_d_vld", {31'h0, fp_d_vld}, 32'h1);
    check_eq("fp_d_dat", fp_d_dat, rom_mem[12]);
    step(); step();

    // Test 6: reset pulse mid-flight drops both issued reads.
    i_req = 1'b1; i_adr = 16'h0040; i_cmdl = 1'b1;
    step();
    #5;
    rst_n = 1'b0; idle();
    #2;
    check_eq("rst6_vld", {29'h0, i_vld, d_vld, d_err}, 32'h0);
    check_eq("rst6_dat", i_dat | d_dat, 32'h0);
    check_eq("rst6_fadr", {16'h0, fadr}, 32'h0);
    step();
    rst_n = 1'b1;
    i_req = 1'b1; d_req = 1'b1; i_adr = 16'h0044; d_adr = 16'h0048;
    #2;
    check_eq("rst6_first_i", {30'h0, i_gnt, d_gnt}, 32'h2);
    step(); i_req = 1'b0; step(); idle();
    check_eq("rst6_i_dat", i_dat, rom_mem[17]);
    step(); step();

    // Random traffic with in-range and out-of-range addresses.
    for (int k = 0; k < 60; k++) begin
      i_req  = 1'($urandom_range(0, 1));
      d_req  = 1'($urandom_range(0, 1));
      i_cmdl = 1'($urandom_range(0, 1));
      d_cmdl = 1'($urandom_range(0, 1));
      i_adr  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
      d_adr  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
      step();
    end
    idle();
    repeat (4) step();
    check_eq("q_drain", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
